// File: rtl/btn_sw_conditioner_pkg.sv
// Shared types and constants for the switch/button input conditioner.
package cond_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHK_HIGH    = 2'd1,
    STABLE_HIGH = 2'd2,
    CHK_LOW     = 2'd3
  } db_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int SIM_DEBOUNCE_CYCLES     = 4;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/btn_sw_conditioner_if.sv
// Pin-side and conditioned-side signals of the input conditioner.
interface btn_sw_conditioner_if #(
  parameter int N_SW  = 8,
  parameter int N_BTN = 4
) ();

  logic [N_SW-1:0]  sw;
  logic [N_BTN-1:0] btn;
  logic [N_SW-1:0]  sw_sync;
  logic [N_BTN-1:0] btn_db;
  logic [N_BTN-1:0] btn_rise;
  logic [N_BTN-1:0] btn_fall;

  modport master (
    output sw, btn,
    input  sw_sync, btn_db, btn_rise, btn_fall
  );

  modport slave (
    input  sw, btn,
    output sw_sync, btn_db, btn_rise, btn_fall
  );

endinterface

// File: rtl/btn_sw_conditioner_debounce_channel.sv
// Single button: 2-flop synchronizer, debounce FSM with run counter, edge pulses.
//
// state       | meaning
// STABLE_LOW  | accepted level 0, waiting for a 1 sample
// CHK_HIGH    | counting consecutive 1 samples before accepting a rise
// STABLE_HIGH | accepted level 1, waiting for a 0 sample
// CHK_LOW     | counting consecutive 0 samples before accepting a fall
module debounce_channel
  import cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $error("debounce_channel: DEBOUNCE_CYCLES must be >= 1");
  end

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam bit            INSTANT  = (DEBOUNCE_CYCLES == 1);

  logic          sync1;
  logic          s;
  db_state_t     state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      state <= STABLE_LOW;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      case (state)
        STABLE_LOW: begin
          if (s) begin
            // With a one-cycle window the first differing sample is already enough.
            if (INSTANT) begin
              state <= STABLE_HIGH;
              level <= 1'b1;
              rise  <= 1'b1;
              cnt   <= '0;
            end else begin
              state <= CHK_HIGH;
              cnt   <= CNT_ONE;
            end
          end else begin
            cnt <= '0;
          end
        end
        CHK_HIGH: begin
          if (!s) begin
            state <= STABLE_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_HIGH;
            level <= 1'b1;
            rise  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STABLE_HIGH: begin
          if (!s) begin
            if (INSTANT) begin
              state <= STABLE_LOW;
              level <= 1'b0;
              fall  <= 1'b1;
              cnt   <= '0;
            end else begin
              state <= CHK_LOW;
              cnt   <= CNT_ONE;
            end
          end else begin
            cnt <= '0;
          end
        end
        CHK_LOW: begin
          if (s) begin
            state <= STABLE_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_LOW;
            level <= 1'b0;
            fall  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= STABLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_sw_conditioner.sv
// Input conditioner: synchronizes switches, synchronizes and debounces buttons.
module btn_sw_conditioner
  import cond_pkg::*;
#(
  parameter int N_SW            = 8,
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  btn_sw_conditioner_if.slave  pins
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $error("btn_sw_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [N_SW-1:0]  sw_meta;
  logic [N_SW-1:0]  sw_sync_q;
  logic [N_BTN-1:0] db_level;
  logic [N_BTN-1:0] db_rise;
  logic [N_BTN-1:0] db_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta   <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta   <= pins.sw;
      sw_sync_q <= sw_meta;
    end
  end

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_channel (
      .clk  (clk),
      .rst  (rst),
      .raw  (pins.btn[gi]),
      .level(db_level[gi]),
      .rise (db_rise[gi]),
      .fall (db_fall[gi])
    );
  end

  assign pins.sw_sync  = sw_sync_q;
  assign pins.btn_db   = db_level;
  assign pins.btn_rise = db_rise;
  assign pins.btn_fall = db_fall;

endmodule

// File: tb/tb_btn_sw_conditioner.sv
// Bench for btn_sw_conditioner: two DUTs (window 4 and window 1) driven by the
// same pins and compared every cycle against a run-length reference model.
module tb_btn_sw_conditioner;
  import cond_pkg::*;

  localparam int N_SW  = 8;
  localparam int N_BTN = 4;
  localparam int D_A   = SIM_DEBOUNCE_CYCLES;
  localparam int D_B   = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  btn_sw_conditioner_if #(.N_SW(N_SW), .N_BTN(N_BTN)) bus_a ();
  btn_sw_conditioner_if #(.N_SW(N_SW), .N_BTN(N_BTN)) bus_b ();

  btn_sw_conditioner #(.N_SW(N_SW), .N_BTN(N_BTN), .DEBOUNCE_CYCLES(D_A)) dut_a (
    .clk (clk),
    .rst (rst),
    .pins(bus_a.slave)
  );

  btn_sw_conditioner #(.N_SW(N_SW), .N_BTN(N_BTN), .DEBOUNCE_CYCLES(D_B)) dut_b (
    .clk (clk),
    .rst (rst),
    .pins(bus_b.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: a button's synchronized sample is the pin value two edges old;
  // a new level is accepted once D consecutive samples differ from the current one.
  int               win [2] = '{D_A, D_B};
  logic [N_SW-1:0]  m_sw1, m_sw2;
  logic [N_BTN-1:0] m_b1, m_b2;
  logic [N_BTN-1:0] m_lvl [2];
  logic [N_BTN-1:0] m_rise[2];
  logic [N_BTN-1:0] m_fall[2];
  int               m_run [2][N_BTN];
  int               cyc = 0;

  task automatic model_reset();
    m_sw1 = '0; m_sw2 = '0; m_b1 = '0; m_b2 = '0;
    for (int d = 0; d < 2; d++) begin
      m_lvl[d] = '0; m_rise[d] = '0; m_fall[d] = '0;
      for (int i = 0; i < N_BTN; i++) m_run[d][i] = 0;
    end
  endtask

  task automatic compare_outputs();
    chk("a_sw_sync",  32'(bus_a.sw_sync),  32'(m_sw2));
    chk("a_btn_db",   32'(bus_a.btn_db),   32'(m_lvl[0]));
    chk("a_btn_rise", 32'(bus_a.btn_rise), 32'(m_rise[0]));
    chk("a_btn_fall", 32'(bus_a.btn_fall), 32'(m_fall[0]));
    chk("b_sw_sync",  32'(bus_b.sw_sync),  32'(m_sw2));
    chk("b_btn_db",   32'(bus_b.btn_db),   32'(m_lvl[1]));
    chk("b_btn_rise", 32'(bus_b.btn_rise), 32'(m_rise[1]));
    chk("b_btn_fall", 32'(bus_b.btn_fall), 32'(m_fall[1]));
    chk("a_rise_fall_excl", 32'(bus_a.btn_rise & bus_a.btn_fall), 32'd0);
  endtask

  task automatic step(input logic r, input logic [N_SW-1:0] s, input logic [N_BTN-1:0] b);
    rst = r;
    bus_a.sw = s; bus_a.btn = b;
    bus_b.sw = s; bus_b.btn = b;
    @(posedge clk);
    cyc++;
    if (r) begin
      model_reset();
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_rise[d] = '0;
        m_fall[d] = '0;
        for (int i = 0; i < N_BTN; i++) begin
          if (m_b2[i] == m_lvl[d][i]) begin
            m_run[d][i] = 0;
          end else begin
            m_run[d][i]++;
            if (m_run[d][i] >= win[d]) begin
              m_lvl[d][i] = m_b2[i];
              if (m_b2[i]) m_rise[d][i] = 1'b1;
              else         m_fall[d][i] = 1'b1;
              m_run[d][i] = 0;
            end
          end
        end
      end
      m_sw2 = m_sw1; m_sw1 = s;
      m_b2  = m_b1;  m_b1  = b;
    end
    #1;
    compare_outputs();
  endtask

  logic [N_SW-1:0]  cur_sw;
  logic [N_BTN-1:0] cur_btn;
  int               hold [N_BTN];
  logic [5:0]       bounce1;
  int               lat_a, lat_b;

  initial begin
    model_reset();
    cur_sw  = '0;
    cur_btn = '0;
    bounce1 = 6'b101101;

    // reset and reset state
    repeat (3) step(1'b1, 8'hFF, 4'hF);
    chk("rst_sw_sync", 32'(bus_a.sw_sync), 32'd0);
    chk("rst_btn_db",  32'(bus_a.btn_db),  32'd0);
    repeat (3) step(1'b0, '0, '0);

    // switches: two-edge synchronizer delay
    step(1'b0, 8'hA5, '0);
    chk("sw_not_yet", 32'(bus_a.sw_sync), 32'd0);
    step(1'b0, 8'hA5, '0);
    chk("sw_after_2", 32'(bus_a.sw_sync), 32'hA5);

    // clean press latency, measured independently of the model
    lat_a = 0; lat_b = 0;
    for (int n = 1; n <= 20; n++) begin
      step(1'b0, 8'hA5, 4'b0001);
      if (lat_a == 0 && bus_a.btn_rise[0]) lat_a = n;
      if (lat_b == 0 && bus_b.btn_rise[0]) lat_b = n;
    end
    chk("latency_d4", 32'(lat_a), 32'(2 + D_A));
    chk("latency_d1", 32'(lat_b), 32'(2 + D_B));

    // reset while btn_db=1 drops the level without a fall pulse
    step(1'b1, 8'hA5, 4'b0001);
    chk("rst_hi_db",   32'(bus_a.btn_db),   32'd0);
    chk("rst_hi_fall", 32'(bus_a.btn_fall), 32'd0);
    repeat (4) step(1'b0, '0, '0);

    // simultaneous press on all channels
    repeat (10) step(1'b0, '0, 4'b1111);
    chk("simul_db", 32'(bus_a.btn_db), 32'hF);

    // bounce on btn[1] then held
    repeat (6) step(1'b1, '0, '0);
    for (int i = 0; i < 6; i++) step(1'b0, '0, {2'b00, bounce1[i], 1'b0});
    repeat (10) step(1'b0, '0, 4'b0010);

    // release of btn[2] preceded by 3-cycle low glitches
    repeat (10) step(1'b0, '0, 4'b0100);
    for (int g = 0; g < 2; g++) begin
      repeat (3) step(1'b0, '0, 4'b0000);
      repeat (5) step(1'b0, '0, 4'b0100);
    end
    repeat (10) step(1'b0, '0, 4'b0000);

    // reset in the middle of a pending rise, button still held afterwards
    repeat (3) step(1'b0, '0, 4'b0001);
    step(1'b1, '0, 4'b0001);
    repeat (10) step(1'b0, '0, 4'b0001);
    repeat (10) step(1'b0, '0, 4'b0000);

    // randomized bouncing: each channel holds a level for 1..7 cycles
    for (int i = 0; i < N_BTN; i++) hold[i] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N_BTN; i++) begin
        if (hold[i] == 0) begin
          cur_btn[i] = ~cur_btn[i];
          hold[i]    = int'($urandom_range(1, 7));
        end
        hold[i]--;
      end
      if ($urandom_range(0, 7) == 0) cur_sw = N_SW'($urandom);
      step(($urandom_range(0, 299) == 0), cur_sw, cur_btn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
